// File: rtl/hal_pipe_receive_buffer.sv
// rtl/hal_pipe_receive_buffer.sv - receive-side elastic FWFT buffer with registered stop and sticky overflow
module hal_pipe_receive_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int SLACK = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       stop,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - SLACK);
    localparam logic [AW-1:0] LAST_C   = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;
    logic             drop;

    always_comb begin
        pop  = out_valid & out_ready;
        push = in_valid & ((count < FULL_C) | pop);
        drop = in_valid & (count == FULL_C) & ~pop;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Storage is deliberately not reset; out_data is meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            stop      <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + AW'(1);
            end
            count     <= count_next;
            out_valid <= (count_next != '0);
            stop      <= (count_next >= THRESH_C);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    if (DEPTH < 2) begin : g_bad_depth
        $error("hal_pipe_receive_buffer: DEPTH must be at least 2");
    end
    if (SLACK < 1 || SLACK >= DEPTH) begin : g_bad_slack
        $error("hal_pipe_receive_buffer: SLACK must satisfy 1 <= SLACK < DEPTH");
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_C);
    a_data_known:  assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(in_data));
endmodule

// File: tb/tb_hal_pipe_receive_buffer.sv
// tb/tb_hal_pipe_receive_buffer.sv - scoreboard bench for hal_pipe_receive_buffer
module tb_hal_pipe_receive_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int SLACK = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             stop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;

    int total = 0;
    int bad = 0;

    logic [WIDTH-1:0] sb[$];
    int               m_count = 0;
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] pattern = 32'h1000;

    hal_pipe_receive_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .stop(stop), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake pops the oldest accepted word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("pop_data", 64'(out_data), 64'(sb.pop_front()));
            end
        end
    end

    task automatic model_reset();
        m_count = 0;
        m_ovf   = 1'b0;
        sb.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"},     64'(count),     64'(m_count));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_count != 0));
        chk({tag, "_stop"},      64'(stop),      64'(m_count >= DEPTH - SLACK));
        chk({tag, "_overflow"},  64'(overflow),  64'(m_ovf));
    endtask

    // Called at posedge+2: drive inputs, advance one edge, update the reference, check.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bit pop_m;
        bit push_m;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        pop_m  = (m_count != 0) && r;
        push_m = v && ((m_count < DEPTH) || pop_m);
        if (push_m) sb.push_back(d);
        if (v && !push_m) m_ovf = 1'b1;
        m_count = m_count + int'(push_m) - int'(pop_m);
        check_state("step");
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2 && m_count != 0; i++) step(1'b0, '0, 1'b1);
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_stop", 64'(stop), 64'd1);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_ovf", 64'(overflow), 64'd0);
        end
        #1;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("release_stop", 64'(stop), 64'd0);

        step(1'b1, 32'h11, 1'b0);
        chk("latency_valid", 64'(out_valid), 64'd1);
        step(1'b1, 32'h22, 1'b0);
        step(1'b1, 32'h33, 1'b0);
        chk("three_count", 64'(count), 64'd3);
        drain("order");

        for (int i = 0; i < 12; i++) step(1'b1, WIDTH'(32'h200 + i), 1'b0);
        chk("thresh_stop", 64'(stop), 64'd1);
        step(1'b0, '0, 1'b1);
        chk("thresh_count", 64'(count), 64'd11);
        chk("thresh_unstop", 64'(stop), 64'd0);

        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(32'h300 + i), 1'b0);
        chk("full_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, pattern, 1'b1);
            pattern = pattern + 1;
        end
        chk("full_hold_count", 64'(count), 64'(DEPTH));
        chk("full_hold_ovf", 64'(overflow), 64'd0);

        step(1'b1, 32'hDEAD, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        drain("ovf");
        chk("ovf_sticky", 64'(overflow), 64'd1);

        for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(32'h400 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_ovf", 64'(overflow), 64'd0);
        chk("async_stop", 64'(stop), 64'd1);
        model_reset();
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'hCAFE_0001, 1'b0);
        drain("post_rst");

        for (int i = 0; i < 600; i++) begin
            logic r;
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(1'(($urandom_range(0, 3) != 0)), WIDTH'($urandom), r);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
